// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master
//  Purpose  : APB3 requester. Turns single-beat commands from a local command
//             interface into SETUP/ACCESS transfers and returns read data and
//             error status as a one-cycle response pulse.
//  Options  : APB_MASTER_TIMEOUT_EN - when defined, an ACCESS phase that waits
//             TIMEOUT_CYCLES cycles with PREADY low is terminated with an
//             error/timeout response. When undefined, ACCESS waits forever.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  // Local command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // Local response side
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  // APB3 requester side
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PSELx,
  output logic                  PENABLE,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  // The timeout counter is 8 bits wide, so the limit must fit in 1..255.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_check
    $error("apb_master: TIMEOUT_CYCLES must be in the range 1..255");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;

  logic [ADDR_WIDTH-1:0] paddr_next;
  logic                  pwrite_next;
  logic [DATA_WIDTH-1:0] pwdata_next;
  logic                  psel_next;
  logic                  penable_next;
  logic                  rsp_valid_next;
  logic [DATA_WIDTH-1:0] rsp_rdata_next;
  logic                  rsp_err_next;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0]            wait_cnt;
  logic [7:0]            wait_cnt_next;
  logic [7:0]            wait_cnt_inc;
  logic                  rsp_timeout_q;
  logic                  rsp_timeout_next;

  // Count of ACCESS cycles seen so far with PREADY low, including this one.
  assign wait_cnt_inc = wait_cnt + 8'd1;
  assign rsp_timeout  = rsp_timeout_q;
`else
  assign rsp_timeout  = 1'b0;
`endif

  // Commands are only taken while the bus is idle.
  assign cmd_ready = (state == IDLE);

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and next-output decode for the SETUP/ACCESS sequence.
  always_comb begin
    state_next     = state;
    paddr_next     = PADDR;
    pwrite_next    = PWRITE;
    pwdata_next    = PWDATA;
    psel_next      = PSELx;
    penable_next   = PENABLE;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = rsp_rdata;
    rsp_err_next   = rsp_err;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_cnt_next    = wait_cnt;
    rsp_timeout_next = rsp_timeout_q;
`endif

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          paddr_next  = cmd_addr;
          pwrite_next = cmd_write;
          // Reads put zero on PWDATA so stale write data never leaks out.
          pwdata_next = cmd_write ? cmd_wdata : '0;
          psel_next   = 1'b1;
          state_next  = SETUP;
        end
      end

      SETUP: begin
        penable_next = 1'b1;
        state_next   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_next = '0;
`endif
      end

      ACCESS: begin
        if (PREADY) begin
          // Normal completion; also wins over a timeout on the same edge.
          rsp_valid_next = 1'b1;
          rsp_err_next   = PSLVERR;
          rsp_rdata_next = PWRITE ? '0 : PRDATA;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          state_next     = IDLE;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_timeout_next = 1'b0;
`endif
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (wait_cnt_inc == TIMEOUT_LIMIT) begin
          // Completer never answered: force the transfer closed.
          rsp_valid_next   = 1'b1;
          rsp_err_next     = 1'b1;
          rsp_timeout_next = 1'b1;
          rsp_rdata_next   = '0;
          psel_next        = 1'b0;
          penable_next     = 1'b0;
          state_next       = IDLE;
          wait_cnt_next    = wait_cnt_inc;
        end else begin
          wait_cnt_next = wait_cnt_inc;
        end
`endif
      end

      default: begin
        psel_next    = 1'b0;
        penable_next = 1'b0;
        state_next   = IDLE;
      end
    endcase
  end

  // APB and response output registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      PADDR     <= paddr_next;
      PWRITE    <= pwrite_next;
      PWDATA    <= pwdata_next;
      PSELx     <= psel_next;
      PENABLE   <= penable_next;
      rsp_valid <= rsp_valid_next;
      rsp_rdata <= rsp_rdata_next;
      rsp_err   <= rsp_err_next;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  // ACCESS wait counter and sticky timeout flag.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wait_cnt      <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      wait_cnt      <= wait_cnt_next;
      rsp_timeout_q <= rsp_timeout_next;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_master
//  Purpose  : Directed, table-driven bench for apb_master with a small APB
//             completer model (16-word memory, error above address 0xF).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic          PSELx;
  logic          PENABLE;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  apb_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PADDR      (PADDR),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PSELx      (PSELx),
    .PENABLE    (PENABLE),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  // Completer model: 16 words, addresses >= 0x10 answer with an error.
  logic [DW-1:0] mem [16];

  assign PRDATA  = (PADDR < 32'd16) ? mem[PADDR[3:0]] : 32'hBAD0_BAD0;
  assign PSLVERR = (PADDR >= 32'd16);

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 + 32'(i);
    end else if (PSELx && PENABLE && PREADY && PWRITE && (PADDR < 32'd16)) begin
      mem[PADDR[3:0]] <= PWDATA;
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;          // ACCESS cycles with PREADY low before completion
    logic        ready_in_setup; // drive PREADY high during SETUP (must be ignored)
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  // One full transfer, checked cycle by cycle. Called at a negedge with the DUT idle.
  task automatic run_xfer(input vec_t v);
    logic [31:0] exp_pwdata;
    exp_pwdata = v.write ? v.wdata : 32'h0;
    chk1("idle_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    PREADY    = v.ready_in_setup;
    @(negedge clk);
    // SETUP cycle; scramble command inputs to prove they were captured
    cmd_valid = 1'b0;
    cmd_addr  = 32'hFFFF_FFF0;
    cmd_wdata = 32'h5555_AAAA;
    cmd_write = ~v.write;
    chk1("setup_psel", PSELx, 1'b1);
    chk1("setup_penable", PENABLE, 1'b0);
    chk1("setup_ready", cmd_ready, 1'b0);
    chk32("setup_paddr", PADDR, v.addr);
    chk1("setup_pwrite", PWRITE, v.write);
    chk32("setup_pwdata", PWDATA, exp_pwdata);
    for (int k = 0; k <= v.waits; k++) begin
      @(negedge clk);
      chk1("access_psel", PSELx, 1'b1);
      chk1("access_penable", PENABLE, 1'b1);
      chk32("access_paddr", PADDR, v.addr);
      chk32("access_pwdata", PWDATA, exp_pwdata);
      chk1("access_no_rsp", rsp_valid, 1'b0);
      PREADY = (k == v.waits);
    end
    @(negedge clk);
    PREADY = 1'b0;
    chk1("rsp_valid", rsp_valid, 1'b1);
    chk32("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk1("rsp_err", rsp_err, v.exp_err);
    chk1("rsp_timeout", rsp_timeout, 1'b0);
    chk1("done_psel", PSELx, 1'b0);
    chk1("done_penable", PENABLE, 1'b0);
    chk1("done_ready", cmd_ready, 1'b1);
    @(negedge clk);
    chk1("rsp_pulse", rsp_valid, 1'b0);
    chk32("rsp_rdata_hold", rsp_rdata, v.exp_rdata);
    chk1("rsp_err_hold", rsp_err, v.exp_err);
  endtask

  vec_t vecs [8];

  initial begin
    int nacc;
    int last_acc;
    int pulses;
    int n_en;
    vec_t v;

    vecs[0] = '{1'b1, 32'h0000_0003, 32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0003, 32'h0000_0000, 0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 0, 1'b0, 32'hBAD0_BAD0, 1'b1};
    vecs[3] = '{1'b1, 32'h0000_0005, 32'h1234_5678, 2, 1'b1, 32'h0000_0000, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0005, 32'h0000_0000, 4, 1'b0, 32'h1234_5678, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_0020, 32'h1111_2222, 1, 1'b0, 32'h0000_0000, 1'b1};
    vecs[6] = '{1'b0, 32'h0000_0007, 32'h0000_0000, 3, 1'b1, 32'hA5A5_0007, 1'b0};
    vecs[7] = '{1'b0, 32'h0000_0003, 32'h0000_0000, 0, 1'b0, 32'hDEAD_BEEF, 1'b0};

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    PREADY    = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk1("rst_psel", PSELx, 1'b0);
    chk1("rst_penable", PENABLE, 1'b0);
    chk1("rst_pwrite", PWRITE, 1'b0);
    chk32("rst_paddr", PADDR, 32'h0);
    chk32("rst_pwdata", PWDATA, 32'h0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk1("rst_rsp_timeout", rsp_timeout, 1'b0);
    chk32("rst_rsp_rdata", rsp_rdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk1("rst_cmd_ready", cmd_ready, 1'b1);

    // Table of single transfers
    for (int i = 0; i < 8; i++) run_xfer(vecs[i]);

    // cmd_valid held high with three commands queued
    PREADY    = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h8;
    cmd_wdata = 32'hC0DE_0000;
    nacc      = 0;
    last_acc  = 0;
    pulses    = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (rsp_valid) pulses++;
      chk1("b2b_ready_only_idle", cmd_ready, ~PSELx);
      if (!cmd_ready) begin
        cmd_valid = (nacc < 3);
        cmd_addr  = 32'h8 + 32'(nacc);
        cmd_wdata = 32'hC0DE_0000 + 32'(nacc);
      end else if (cmd_valid) begin
        if (nacc > 0) chki("b2b_spacing", cyc - last_acc, 3);
        last_acc = cyc;
        nacc++;
      end
      @(negedge clk);
    end
    PREADY    = 1'b0;
    cmd_valid = 1'b0;
    chki("b2b_accepts", nacc, 3);
    chki("b2b_pulses", pulses, 3);
    v = '{1'b0, 32'h0000_0009, 32'h0, 0, 1'b0, 32'hC0DE_0001, 1'b0};
    run_xfer(v);

    // Reset in the middle of ACCESS aborts without a response
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h3;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk1("abort_in_access", PENABLE, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    chk1("abort_psel", PSELx, 1'b0);
    chk1("abort_penable", PENABLE, 1'b0);
    chk1("abort_ready", cmd_ready, 1'b1);
    chk1("abort_no_rsp", rsp_valid, 1'b0);
    reset_n = 1'b1;
    PREADY  = 1'b1;
    pulses  = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    PREADY = 1'b0;
    chki("abort_no_late_rsp", pulses, 0);

    // PREADY rising on the edge where the limit would be reached completes normally
    v = '{1'b0, 32'h0000_0004, 32'h0, TIMEOUT - 1, 1'b0, 32'hA5A5_0004, 1'b0};
    run_xfer(v);

    // PREADY stuck low
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h4;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_en = 0;
`ifdef APB_MASTER_TIMEOUT_EN
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (PENABLE) n_en++;
    end
    chk1("to_rsp_valid", rsp_valid, 1'b1);
    chki("to_wait_cycles", n_en, TIMEOUT);
    chk1("to_rsp_err", rsp_err, 1'b1);
    chk1("to_rsp_timeout", rsp_timeout, 1'b1);
    chk32("to_rsp_rdata", rsp_rdata, 32'h0);
    chk1("to_psel", PSELx, 1'b0);
    chk1("to_penable", PENABLE, 1'b0);
    @(negedge clk);
    chk1("to_pulse", rsp_valid, 1'b0);
    chk1("to_timeout_hold", rsp_timeout, 1'b1);
    v = '{1'b0, 32'h0000_0003, 32'h0, 0, 1'b0, 32'hA5A5_0003, 1'b0};
    run_xfer(v);
`else
    for (int cyc = 0; cyc < 120; cyc++) begin
      @(negedge clk);
      if (PENABLE && !rsp_valid) n_en++;
    end
    chki("no_to_stuck_cycles", n_en, 120);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk1("no_to_recover_ready", cmd_ready, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester that converts single-beat commands from a local command interface into APB3 transfers: SETUP phase, ACCESS phase, PREADY wait.
- Drives the bus side of the team's apb_slave, and any other APB3 completer.
- Returns read data and the error status to the requester as a one-cycle response pulse.
- Sits between a host-side controller (CPU bridge, test sequencer) and the APB peripheral bus.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and PADDR.
- DATA_WIDTH, 32, width of write/read data paths.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before forced termination. Used only with APB_MASTER_TIMEOUT_EN; legal range 1..255.

Ports:
- i_clk  input  1  APB clock
- i_reset_n  input  1  synchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  block can accept a command
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_WIDTH  target address
- cmd_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  one-cycle pulse: transfer complete
- rsp_rdata  output  DATA_WIDTH  read data (0 for writes)
- rsp_err  output  1  PSLVERR sampled at completion, or timeout
- rsp_timeout  output  1  completion caused by timeout
- PADDR  output  ADDR_WIDTH  APB address
- PWRITE  output  1  APB direction
- PWDATA  output  DATA_WIDTH  APB write data
- PSELx  output  1  APB select
- PENABLE  output  1  APB enable
- PRDATA  input  DATA_WIDTH  APB read data
- PREADY  input  1  APB ready
- PSLVERR  input  1  APB error

Behaviour:
- Reset: i_reset_n is synchronous and active-low; clock is i_clk. All outputs are driven from registers.
- Values while in reset or at initial: state = IDLE; PSELx = PENABLE = PWRITE = 0; PADDR = PWDATA = 0; rsp_valid = rsp_err = rsp_timeout = 0; rsp_rdata = 0.
- Reset asserted mid-transfer aborts the transfer immediately. No rsp_valid is issued for the aborted command.
- cmd_ready = 1 only in IDLE; it is a combinational decode of the state register.
- State machine, states IDLE, SETUP, ACCESS:
  - IDLE: on cmd_valid && cmd_ready, register cmd_addr/cmd_write/cmd_wdata onto PADDR/PWRITE/PWDATA, set PSELx = 1 and go to SETUP. PWDATA is set to 0 for reads.
  - SETUP (exactly 1 cycle): PSELx = 1, PENABLE = 0. Next edge sets PENABLE = 1 and goes to ACCESS.
  - ACCESS: PSELx = PENABLE = 1. PADDR/PWRITE/PWDATA are held stable for the whole transfer.
    - On an edge with PREADY = 1: rsp_valid = 1, rsp_err = PSLVERR, rsp_rdata = PRDATA for reads or 0 for writes. Then PSELx = PENABLE = 0 and the state returns to IDLE.
    - PREADY = 0: stay in ACCESS.
- rsp_valid is high for exactly one cycle. rsp_rdata/rsp_err/rsp_timeout hold their value until the next completion. There is no response backpressure.
- Latency:
  - Accept edge to the first SETUP cycle: 1 cycle.
  - Minimum transfer (PREADY high in the first ACCESS cycle): rsp_valid 3 cycles after the accept edge.
  - No back-to-back pipelining: each transfer returns through IDLE, so the minimum command spacing is 3 cycles.
- PREADY/PSLVERR/PRDATA are ignored outside ACCESS.
- PSLVERR is only meaningful when PREADY = 1.
- cmd_* inputs are ignored outside IDLE.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entering ACCESS and increments each ACCESS cycle with PREADY = 0.
  - When the counter reaches TIMEOUT_CYCLES with PREADY still 0, the transfer terminates on that edge: rsp_valid = 1, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0; PSELx = PENABLE = 0; state returns to IDLE.
  - PREADY = 1 on the same edge as the limit wins and completes normally.
- Undefined: no counter; ACCESS waits indefinitely for PREADY; rsp_timeout is tied to 0.

Test Plan:
- Write 0x0000_0003 data 0xDEAD_BEEF with PREADY high in the first ACCESS cycle -> cycles show PSELx=1/PENABLE=0, then 1/1. rsp_valid 3 cycles after accept; rsp_err = 0. PADDR/PWDATA stable throughout.
- Read 0x3 against apb_slave after the previous write -> rsp_rdata = 0xDEAD_BEEF, rsp_err = 0. Read 0x10 -> rsp_err = 1.
- PREADY held low 4 ACCESS cycles, then high with PRDATA = 0x1234_5678 -> PENABLE high 5 cycles; rsp_rdata = 0x1234_5678; rsp_valid a single pulse.
- cmd_valid held high continuously with 3 commands queued -> each accepted only in IDLE, spacing ≥ 3 cycles, 3 rsp_valid pulses, no accept during SETUP/ACCESS.
- Reset asserted during ACCESS -> next cycle PSELx = PENABLE = 0, cmd_ready = 1, no rsp_valid.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 16, PREADY stuck low -> rsp_valid after the 16th waiting ACCESS cycle, rsp_err = rsp_timeout = 1, rsp_rdata = 0. Without the macro, the block stays in ACCESS for 100+ cycles.
